// File: rtl/alu_arbiter_if.sv
// Handshake and datapath bundle between the requesters, the shared ALU and
// the response consumer. The arbiter connects through the slave modport.
interface alu_arbiter_if;
    logic       req0_valid, req0_ready;
    logic [2:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [2:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_op1, alu_op2, alu_result;
    logic [3:0] alu_flags;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, alu_flags, rsp_ready,
        output req0_ready, req1_ready, alu_sel, alu_op1, alu_op2,
        output rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, alu_flags, rsp_ready,
        input  req0_ready, req1_ready, alu_sel, alu_op1, alu_op2,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared 8-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module alu_arbiter #(
    parameter logic INIT_LAST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] op1_q, op1_d, op2_q, op2_d;
    logic       id_q, id_d;
    logic [7:0] res_q, res_d;
    logic [3:0] flg_q, flg_d;
    logic       grant0, grant1, in_idle;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant0 = bus.req0_valid;
    assign grant1 = bus.req1_valid && !bus.req0_valid;
`else
    // last_q holds the id granted most recently; the other side wins a tie
    logic last_q, last_d;
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
    assign grant1 = bus.req1_valid && !grant0;
`endif

    assign in_idle        = (state_q == IDLE) && !rst;
    assign bus.req0_ready = in_idle && grant0;
    assign bus.req1_ready = in_idle && grant1;

    assign bus.alu_sel    = sel_q;
    assign bus.alu_op1    = op1_q;
    assign bus.alu_op2    = op2_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_flags  = flg_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        id_d    = id_q;
        res_d   = res_q;
        flg_d   = flg_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: if (grant0 || grant1) begin
                sel_d   = grant1 ? bus.req1_op : bus.req0_op;
                op1_d   = grant1 ? bus.req1_a  : bus.req0_a;
                op2_d   = grant1 ? bus.req1_b  : bus.req0_b;
                id_d    = grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_d  = grant1;
`endif
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = bus.alu_result;
                flg_d   = bus.alu_flags;
                state_d = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'b000;
            op1_q   <= 8'h00;
            op2_q   <= 8'h00;
            id_q    <= 1'b0;
            res_q   <= 8'h00;
            flg_q   <= 4'h0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= INIT_LAST;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            id_q    <= id_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 8-bit ALU datapath between two independent requesters, such as the instruction execute stage and the address/loop-counter unit. Each requester submits an opcode and two operands over a valid/ready handshake. The block grants one requester at a time, drives the ALU from registered operands and captures the result and NZVC flags into a response register. The response is held until the consumer accepts it.

## Interface
Parameters:
- INIT_LAST, default 1'b1: requester treated as most-recently-granted after reset, so requester 0 wins the first tie.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  3  requester 0 ALU operation select.
- req0_a, req0_b  in  8  requester 0 operand1 and operand2.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as above, for requester 1.
- alu_sel  out  3  operation select to ALU.
- alu_op1, alu_op2  out  8  operands to ALU.
- alu_result  in  8  combinational ALU result.
- alu_flags  in  4  combinational ALU flags {N,Z,V,C}.
- rsp_valid  out  1  response holding.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  8  captured result.
- rsp_flags  out  4  captured {N,Z,V,C}.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any reqN_valid, pick a winner and assert its reqN_ready combinationally in the same cycle.
  - Register the winner's op/a/b into alu_sel/alu_op1/alu_op2 and its id into rsp_id.
  - Update the last-grant record, then go to EXEC.
  - Only one ready is ever high; ready is never high outside IDLE.
- **Arbitration (round-robin)**
  - When both requesters are valid, the one not granted last wins.
  - When a single requester is valid, it wins regardless of history.
- **EXEC**
  - ALU inputs are stable for the whole cycle.
  - At the clock edge, capture alu_result into rsp_result and alu_flags into rsp_flags, then go to RESP.
- **RESP**
  - rsp_valid=1. rsp_id, rsp_result and rsp_flags are held stable.
  - On rsp_ready=1, go to IDLE.
  - No new request is accepted in the cycle the response drains.
- **ALU input registers** hold their last values in RESP and IDLE and change only on acceptance.
- **Flags** are passed through unmodified. The block does not interpret opcodes.
- **Requester-side inputs** are ignored except in IDLE. A requester may drop valid before it is granted without error.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=8'h00, rsp_flags=4'h0, alu_sel=3'b000, alu_op1=8'h00, alu_op2=8'h00, req0_ready=0, req1_ready=0, state=IDLE, last grant=INIT_LAST.
- Latency: accepted at edge N, ALU driven during cycle N+1, rsp_valid high from cycle N+2.
- Minimum issue interval: 3 cycles, when rsp_ready is held at 1.
- Backpressure: rsp_valid stays high and all rsp_* stay constant until rsp_ready=1; there is no timeout.
- Reset asserted in EXEC or RESP discards the in-flight operation: no response is produced and the FSM returns to IDLE on the next edge.
- Reset has priority over every other event, including a simultaneous valid or rsp_ready.
- req0_ready and req1_ready are forced to 0 while rst=1.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins when both are valid. The last-grant record and INIT_LAST are unused.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset release, then req0 op=000 a=8'h7F b=8'h01 with ALU model attached: req0_ready in the accept cycle; rsp_valid two cycles later with rsp_id=0, rsp_result=8'h80, rsp_flags=4'b1010.
- Both requesters valid continuously, rsp_ready=1: grants alternate 0,1,0,1, with one accept every 3 cycles.
  - With ALU_ARB_FIXED_PRIO_EN defined, every grant goes to 0.
- Hold rsp_ready=0 for 5 cycles after a response: rsp_* are constant, no ready is asserted, and a pending req1 is accepted only in the cycle after rsp_ready=1.
- req1 op=001 a=8'h00 b=8'h01: rsp_id=1, rsp_result=8'hFF, C flag=1.
  - Verify alu_sel/alu_op1/alu_op2 are unchanged through the RESP state.
- Assert rst during EXEC: no rsp_valid pulse; all outputs return to their reset values; the next request completes normally.
- req0_valid pulses for one cycle while the FSM is in RESP, then deasserts: it is never granted and no spurious response occurs.
